// File: rtl/mini_src_pkg.sv
// Shared definitions for the mini SRC instruction step sequencer.
// Holds the state encodings (also driven out on the step port), opcode
// constants, ALU operation codes and the instruction-class enumeration
// used by the opcode decoder and the sequencer FSM.
package mini_src_pkg;

  localparam int OPC_W = 5;
  localparam int ALU_W = 5;

  // State codes are visible externally through the step output.
  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_HALT = 4'd8
  } state_e;

  typedef enum logic [2:0] {
    CLS_R    = 3'd0,
    CLS_I    = 3'd1,
    CLS_MD   = 3'd2,
    CLS_UN   = 3'd3,
    CLS_NOP  = 3'd4,
    CLS_HALT = 3'd5,
    CLS_ILL  = 3'd6
  } iclass_e;

  localparam logic [OPC_W-1:0] OPC_R_LO = 5'd3;
  localparam logic [OPC_W-1:0] OPC_R_HI = 5'd11;
  localparam logic [OPC_W-1:0] OPC_ADDI = 5'd12;
  localparam logic [OPC_W-1:0] OPC_ANDI = 5'd13;
  localparam logic [OPC_W-1:0] OPC_ORI  = 5'd14;
  localparam logic [OPC_W-1:0] OPC_MUL  = 5'd15;
  localparam logic [OPC_W-1:0] OPC_DIV  = 5'd16;
  localparam logic [OPC_W-1:0] OPC_NEG  = 5'd17;
  localparam logic [OPC_W-1:0] OPC_NOT  = 5'd18;
  localparam logic [OPC_W-1:0] OPC_NOP  = 5'd26;
  localparam logic [OPC_W-1:0] OPC_HALT = 5'd27;

  localparam logic [ALU_W-1:0] ALU_NONE = 5'd0;
  localparam logic [ALU_W-1:0] ALU_ADD  = 5'd3;
  localparam logic [ALU_W-1:0] ALU_AND  = 5'd5;
  localparam logic [ALU_W-1:0] ALU_OR   = 5'd6;

endpackage

// File: rtl/isq_decode.sv
// Combinational opcode decoder for the instruction step sequencer.
// Ports:
//   opcode   in  5  instruction opcode (top five IR bits)
//   iclass   out    instruction class driving the execute-step pattern
//   alu_ctrl out 5  ALU operation used in T4 (0 for non-ALU classes)
module isq_decode
  import mini_src_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output iclass_e          iclass,
  output logic [ALU_W-1:0] alu_ctrl
);

  // Classify the opcode; immediate forms remap onto their register-form ALU code.
  always_comb begin
    iclass   = CLS_ILL;
    alu_ctrl = ALU_NONE;
    if ((opcode >= OPC_R_LO) && (opcode <= OPC_R_HI)) begin
      iclass   = CLS_R;
      alu_ctrl = opcode;
    end else if (opcode == OPC_ADDI) begin
      iclass   = CLS_I;
      alu_ctrl = ALU_ADD;
    end else if (opcode == OPC_ANDI) begin
      iclass   = CLS_I;
      alu_ctrl = ALU_AND;
    end else if (opcode == OPC_ORI) begin
      iclass   = CLS_I;
      alu_ctrl = ALU_OR;
    end else if ((opcode == OPC_MUL) || (opcode == OPC_DIV)) begin
      iclass   = CLS_MD;
      alu_ctrl = opcode;
    end else if ((opcode == OPC_NEG) || (opcode == OPC_NOT)) begin
      iclass   = CLS_UN;
      alu_ctrl = opcode;
    end else if (opcode == OPC_NOP) begin
      iclass   = CLS_NOP;
      alu_ctrl = ALU_NONE;
    end else if (opcode == OPC_HALT) begin
      iclass   = CLS_HALT;
      alu_ctrl = ALU_NONE;
    end else begin
      iclass   = CLS_ILL;
      alu_ctrl = ALU_NONE;
    end
  end

endmodule

// File: rtl/instr_step_sequencer.sv
// Fetch/execute control-step sequencer for a mini SRC datapath.
// Walks IDLE -> T0..T6 and emits the register-transfer strobes for each step,
// waiting in T1 for memory with a bounded wait counter, and counting retired
// instructions.
// Ports:
//   clk, clr (async active-low reset)
//   start, run, mem_ready, ir[IR_W]        control inputs and instruction
//   pc_out..ir_en                           fetch strobes
//   gra..hi_en, alu_ctrl[5]                 execute strobes
//   step[4], busy, done, illegal, timeout, halted   status
//   instr_count[CNT_W]                      retired-instruction counter
module instr_step_sequencer
  import mini_src_pkg::*;
#(
  parameter int IR_W   = 32,
  parameter int WAIT_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             run,
  input  logic             mem_ready,
  input  logic [IR_W-1:0]  ir,
  output logic             pc_out,
  output logic             mar_en,
  output logic             pc_inc,
  output logic             read,
  output logic             mdr_en,
  output logic             mdr_out,
  output logic             ir_en,
  output logic             gra,
  output logic             grb,
  output logic             grc,
  output logic             rin,
  output logic             rout,
  output logic             c_out,
  output logic             y_en,
  output logic             z_en,
  output logic             zlo_out,
  output logic             zhi_out,
  output logic             lo_en,
  output logic             hi_en,
  output logic [ALU_W-1:0] alu_ctrl,
  output logic [3:0]       step,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic             timeout,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

  state_e            state_r;
  state_e            state_nxt_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic [CNT_W-1:0]  instr_count_r;
  iclass_e           iclass_s;
  logic [ALU_W-1:0]  dec_alu_s;
  logic              ir_unused_s;

  // Only the opcode field steers sequencing; the operand fields are not used here.
  assign ir_unused_s = ^ir[IR_W-OPC_W-1:0];

  isq_decode u_decode (
    .opcode   (ir[IR_W-1 -: OPC_W]),
    .iclass   (iclass_s),
    .alu_ctrl (dec_alu_s)
  );

  assign step        = state_r;
  assign instr_count = instr_count_r;

  // State register, T1 wait counter and retire counter.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_r       <= ST_IDLE;
      wait_cnt_r    <= {WAIT_W{1'b0}};
      instr_count_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      // Counts consecutive T1 cycles without mem_ready; cleared on any other cycle.
      if ((state_r == ST_T1) && !mem_ready && (wait_cnt_r != WAIT_MAX)) begin
        wait_cnt_r <= wait_cnt_r + {{(WAIT_W-1){1'b0}}, 1'b1};
      end else begin
        wait_cnt_r <= {WAIT_W{1'b0}};
      end
      if (done) begin
        instr_count_r <= instr_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        instr_count_r <= instr_count_r;
      end
    end
  end

  // Next-state and step strobes, decoded from the current state and instruction class.
  always_comb begin
    state_nxt_s = state_r;
    pc_out  = 1'b0; mar_en  = 1'b0; pc_inc  = 1'b0; read    = 1'b0;
    mdr_en  = 1'b0; mdr_out = 1'b0; ir_en   = 1'b0;
    gra     = 1'b0; grb     = 1'b0; grc     = 1'b0; rin     = 1'b0;
    rout    = 1'b0; c_out   = 1'b0; y_en    = 1'b0; z_en    = 1'b0;
    zlo_out = 1'b0; zhi_out = 1'b0; lo_en   = 1'b0; hi_en   = 1'b0;
    alu_ctrl = ALU_NONE;
    done    = 1'b0; illegal = 1'b0; timeout = 1'b0; halted  = 1'b0;
    busy    = (state_r != ST_IDLE) && (state_r != ST_HALT);
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_T0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_T0: begin
        pc_out = 1'b1; mar_en = 1'b1; pc_inc = 1'b1;
        state_nxt_s = ST_T1;
      end
      ST_T1: begin
        read = 1'b1; mdr_en = 1'b1;
        // A full wait counter means the budget of wait cycles is spent: give up.
        if (wait_cnt_r == WAIT_MAX) begin
          timeout     = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (mem_ready) begin
          state_nxt_s = ST_T2;
        end else begin
          state_nxt_s = ST_T1;
        end
      end
      ST_T2: begin
        mdr_out = 1'b1; ir_en = 1'b1;
        state_nxt_s = ST_T3;
      end
      ST_T3: begin
        case (iclass_s)
          CLS_R, CLS_I, CLS_UN: begin
            grb = 1'b1; rout = 1'b1; y_en = 1'b1;
            state_nxt_s = ST_T4;
          end
          CLS_MD: begin
            gra = 1'b1; rout = 1'b1; y_en = 1'b1;
            state_nxt_s = ST_T4;
          end
          CLS_NOP: begin
            done        = 1'b1;
            state_nxt_s = run ? ST_T0 : ST_IDLE;
          end
          CLS_HALT: begin
            state_nxt_s = ST_HALT;
          end
          default: begin
            illegal     = 1'b1;
            state_nxt_s = ST_IDLE;
          end
        endcase
      end
      ST_T4: begin
        case (iclass_s)
          CLS_R: begin
            grc = 1'b1; rout = 1'b1; z_en = 1'b1; alu_ctrl = dec_alu_s;
            state_nxt_s = ST_T5;
          end
          CLS_I: begin
            c_out = 1'b1; z_en = 1'b1; alu_ctrl = dec_alu_s;
            state_nxt_s = ST_T5;
          end
          CLS_MD: begin
            grb = 1'b1; rout = 1'b1; z_en = 1'b1; alu_ctrl = dec_alu_s;
            state_nxt_s = ST_T5;
          end
          CLS_UN: begin
            z_en = 1'b1; alu_ctrl = dec_alu_s;
            state_nxt_s = ST_T5;
          end
          default: begin
            state_nxt_s = ST_IDLE;
          end
        endcase
      end
      ST_T5: begin
        case (iclass_s)
          CLS_R, CLS_I, CLS_UN: begin
            zlo_out = 1'b1; gra = 1'b1; rin = 1'b1;
            done        = 1'b1;
            state_nxt_s = run ? ST_T0 : ST_IDLE;
          end
          CLS_MD: begin
            zlo_out = 1'b1; lo_en = 1'b1;
            state_nxt_s = ST_T6;
          end
          default: begin
            state_nxt_s = ST_IDLE;
          end
        endcase
      end
      ST_T6: begin
        if (iclass_s == CLS_MD) begin
          zhi_out = 1'b1; hi_en = 1'b1;
          done        = 1'b1;
          state_nxt_s = run ? ST_T0 : ST_IDLE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_HALT: begin
        halted      = 1'b1;
        state_nxt_s = ST_HALT;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

endmodule

// File: doc/instr_step_sequencer.md
INSTR_STEP_SEQUENCER -- requirements
Module: instr_step_sequencer

Interface
REQ-001 Parameter IR_W, default 32: instruction register width; opcode is ir[IR_W-1 -: 5].
REQ-002 Parameter WAIT_W, default 4: memory-wait counter width; timeout at 2**WAIT_W-1 wait cycles.
REQ-003 Parameter CNT_W, default 16: retired-instruction counter width.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 clr  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  in IDLE, begin fetch; ignored elsewhere.
REQ-007 run  in  1  sampled at last step; 1 = fetch next instruction back-to-back.
REQ-008 mem_ready  in  1  memory read complete.
REQ-009 ir  in  IR_W  current IR contents, valid from T3.
REQ-010 pc_out, mar_en, pc_inc, read, mdr_en, mdr_out, ir_en  out  1 each  fetch strobes.
REQ-011 gra, grb, grc, rin, rout, c_out, y_en, z_en, zlo_out, zhi_out, lo_en, hi_en  out  1 each  execute strobes.
REQ-012 alu_ctrl  out  5  ALU operation code.
REQ-013 step  out  4  current state code; busy, done, illegal, timeout, halted  out  1 each  status.
REQ-014 instr_count  out  CNT_W  retired instructions, wraps to 0.

Function
REQ-015 States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT; all outputs are decoded from the state register and asserted for the whole cycle that state is current.
REQ-016 IDLE -> T0 when start=1; busy=1 in every state except IDLE and HALT.
REQ-017 T0: pc_out, mar_en, pc_inc; -> T1.
REQ-018 T1: read, mdr_en; stay in T1 while mem_ready=0; -> T2 on the cycle mem_ready=1.
REQ-019 T1 wait count reaching 2**WAIT_W-1 without mem_ready: timeout=1 for one cycle, -> IDLE, no retire.
REQ-020 T2: mdr_out, ir_en; -> T3.
REQ-021 R-type (opcode 00011..01011): T3 grb, rout, y_en; T4 grc, rout, z_en, alu_ctrl=opcode; T5 zlo_out, gra, rin; last step T5.
REQ-022 I-type: opcode 01100 -> alu_ctrl 00011, 01101 -> 00101, 01110 -> 00110; T4 uses c_out instead of grc, rout; otherwise as REQ-021.
REQ-023 Mul/div (01111, 10000): T3 gra, rout, y_en; T4 grb, rout, z_en, alu_ctrl=opcode; T5 zlo_out, lo_en; T6 zhi_out, hi_en; last step T6.
REQ-024 Unary (10001, 10010): T3 grb, rout, y_en; T4 z_en, alu_ctrl=opcode; T5 zlo_out, gra, rin; last step T5.
REQ-025 Nop (11010): last step T3 with no strobes; halt (11011): T3 -> HALT, halted=1, remains in HALT until reset; start ignored in HALT.
REQ-026 Any other opcode: illegal=1 during T3, no execute strobes, -> IDLE, no retire.
REQ-027 alu_ctrl=00000 in every state not listed above.
REQ-028 Last step: done=1 and instr_count increments (mod 2**CNT_W); next state T0 if run=1, else IDLE.
REQ-029 At most one of pc_out, mdr_out, rout, c_out, zlo_out, zhi_out is high in any cycle.

Reset
REQ-030 clr=0 forces state IDLE, wait counter 0, instr_count 0, and all outputs 0 within the same cycle, regardless of state or pending handshake.
REQ-031 Release of clr gives no strobes until start=1.

Structure
REQ-032 Opcode constants, ALU codes, state encodings, and the instruction-class enumeration are defined in the shared mini_src_pkg.
REQ-033 One combinational sub-module, isq_decode, maps opcode to {class, alu_ctrl}; the FSM, wait counter, and retire counter reside in instr_step_sequencer.

Verification
REQ-034 Directed: ir=0x18000000 (add), mem_ready high in T1 -> T0..T5 in 6 cycles; T4 alu_ctrl=00011, grc=1; done in T5; instr_count=1.
REQ-035 Directed: ir=0x60000000 (addi), 3 wait cycles -> T1 held 4 cycles; T4 c_out=1, alu_ctrl=00011.
REQ-036 Directed: ir=0x78000000 (mul) -> T5 lo_en, T6 hi_en, zhi_out; done in T6; with run=1 -> T0 next cycle.
REQ-037 Directed: mem_ready held 0 -> timeout pulse after 15 wait cycles, return to IDLE, instr_count unchanged.
REQ-038 Directed: ir=0xD8000000 (halt) -> HALT, halted=1, start ignored; opcode 00000 -> illegal pulse in T3.
REQ-039 Directed: clr low mid-T4 -> all outputs 0 immediately; IDLE after release; instr_count=0.
